sequential_carryless_multiplier: RTL and testbench

//   Multi-cycle carry-less (GF(2) polynomial) multiplier. It supports the three RISC-V Zbc

---
 rtl/sequential_carryless_multiplier.sv | 122 ++++++++++++
 tb/tb_sequential_carryless_multiplier.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequential_carryless_multiplier.sv
// Multi-cycle GF(2) polynomial multiplier with CLMUL / CLMULH / CLMULR result selection.
// Consumes BITS_PER_CYCLE bits of operand B per clock behind valid/ready handshakes.
module sequential_carryless_multiplier #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] operand_A_i,
    input  logic [DATA_WIDTH-1:0] operand_B_i,
    input  logic [1:0]            mode_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int N     = DATA_WIDTH;
    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = N / BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t           state;
    logic [2*N-1:0]   acc;
    logic [2*N-1:0]   acc_next;
    logic [2*N-1:0]   a_shift;
    logic [N-1:0]     b_shift;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     result_sel;

    // A is pre-shifted and B consumed from its LSBs, so each step only needs fixed shifts.
    always_comb begin
        acc_next = acc;
        for (int j = 0; j < BPC; j++) begin
            if (b_shift[j]) begin
                acc_next = acc_next ^ (a_shift << j);
            end
        end
    end

    always_comb begin
        result_sel = acc_next[N-1:0];
        case (mode_q)
            2'b01:   result_sel = acc_next[2*N-1:N];
            2'b10:   result_sel = acc_next[2*N-2:N-1];
            default: result_sel = acc_next[N-1:0];
        endcase
    end

    assign ready_o = rst_n_i && ((state == IDLE) || ((state == DONE) && ready_i));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            valid_o  <= 1'b0;
            result_o <= '0;
            acc      <= '0;
            cnt      <= '0;
            a_shift  <= '0;
            b_shift  <= '0;
            mode_q   <= 2'b00;
        end else if (flush_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_shift <= {{N{1'b0}}, operand_A_i};
                        b_shift <= operand_B_i;
                        mode_q  <= mode_i;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc     <= acc_next;
                    a_shift <= a_shift << BPC;
                    b_shift <= b_shift >> BPC;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state    <= DONE;
                        valid_o  <= 1'b1;
                        result_o <= result_sel;
                    end
                end
                DONE: begin
                    // A consumed result may be replaced by a new operation in the same cycle.
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        if (valid_i) begin
                            a_shift <= {{N{1'b0}}, operand_A_i};
                            b_shift <= operand_B_i;
                            mode_q  <= mode_i;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= COMPUTE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_carryless_multiplier.sv
// Self-checking bench for sequential_carryless_multiplier: directed corner cases plus
// randomized operations with output stalls, compared against a bit-serial polynomial model.
module tb_sequential_carryless_multiplier;

    localparam int N       = 32;
    localparam int BPC     = 4;
    localparam int STEPS   = N / BPC;
    localparam int NUM_OPS = 400;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    logic [N-1:0] operand_A_i;
    logic [N-1:0] operand_B_i;
    logic [1:0]   mode_i;
    logic         valid_o;
    logic         ready_i;
    logic [N-1:0] result_o;

    int checkCount = 0;
    int errorCount = 0;

    sequential_carryless_multiplier #(
        .DATA_WIDTH(N),
        .BITS_PER_CYCLE(BPC)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .flush_i(flush_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .operand_A_i(operand_A_i),
        .operand_B_i(operand_B_i),
        .mode_i(mode_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    // Full polynomial product first, then pick the requested window of it.
    function automatic logic [N-1:0] clmulModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input logic [1:0] m);
        logic [2*N-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) p = p ^ ({{N{1'b0}}, a} << i);
        end
        case (m)
            2'b01:   return p[2*N-1:N];
            2'b10:   return p[2*N-2:N-1];
            default: return p[N-1:0];
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [1:0] m);
        int n;
        n = 0;
        while (!ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!ready_o) checkOutput("accept timeout", 64'd0, 64'd1);
        operand_A_i = a;
        operand_B_i = b;
        mode_i      = m;
        valid_i     = 1'b1;
        tick();
        valid_i     = 1'b0;
        operand_A_i = $urandom;
        operand_B_i = $urandom;
        mode_i      = 2'($urandom_range(0, 3));
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!valid_o && cycles < 200) begin
            tick();
            cycles++;
        end
        if (!valid_o) checkOutput("result timeout", 64'd0, 64'd1);
    endtask

    task automatic consume;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic runOp(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] m,
                         input logic [N-1:0] expected, input string tag);
        int cyc;
        applyStimulus(a, b, m);
        waitResult(cyc);
        checkOutput({tag, " latency"}, 64'(cyc), 64'(STEPS));
        checkOutput({tag, " result"}, 64'(result_o), 64'(expected));
        consume();
        checkOutput({tag, " valid drop"}, 64'(valid_o), 64'd0);
    endtask

    initial begin
        int cyc;
        int stall;
        logic sawValid;
        logic [N-1:0] curA, curB;
        logic [1:0]   curMode;
        logic [N-1:0] expected;
        logic         preAccepted;

        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        valid_i     = 1'b0;
        ready_i     = 1'b0;
        operand_A_i = '0;
        operand_B_i = '0;
        mode_i      = 2'b00;
        tick();
        tick();
        checkOutput("reset ready", 64'(ready_o), 64'd0);
        checkOutput("reset valid", 64'(valid_o), 64'd0);
        checkOutput("reset result", 64'(result_o), 64'd0);
        rst_n_i = 1'b1;
        #1;
        checkOutput("release ready", 64'(ready_o), 64'd1);

        runOp(32'h3, 32'h3, 2'b00, 32'h00000005, "T1 basic");
        runOp(32'h80000000, 32'h80000000, 2'b00, 32'h00000000, "T2 clmul");
        runOp(32'h80000000, 32'h80000000, 2'b01, 32'h40000000, "T2 clmulh");
        runOp(32'h80000000, 32'h80000000, 2'b10, 32'h80000000, "T2 clmulr");
        runOp(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h55555555, "T3 clmul");
        runOp(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h55555555, "T3 clmulh");
        runOp(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hAAAAAAAA, "T3 clmulr");
        runOp(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h55555555, "reserved mode");

        // Backpressure in DONE, then a back-to-back accept on the consuming edge.
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10);
        waitResult(cyc);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("T4 held valid", 64'(valid_o), 64'd1);
            checkOutput("T4 held result", 64'(result_o), 64'hAAAAAAAA);
            checkOutput("T4 stall ready", 64'(ready_o), 64'd0);
        end
        ready_i     = 1'b1;
        valid_i     = 1'b1;
        operand_A_i = 32'h5;
        operand_B_i = 32'h3;
        mode_i      = 2'b00;
        #1;
        checkOutput("T4 b2b ready", 64'(ready_o), 64'd1);
        tick();
        ready_i = 1'b0;
        valid_i = 1'b0;
        checkOutput("T4 b2b valid drop", 64'(valid_o), 64'd0);
        waitResult(cyc);
        checkOutput("T4 b2b latency", 64'(cyc), 64'(STEPS));
        checkOutput("T4 b2b result", 64'(result_o), 64'h0000000F);
        consume();

        // Flush mid-compute must abandon the operation without ever raising valid_o.
        applyStimulus(32'h12345678, 32'h9ABCDEF0, 2'b01);
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checkOutput("T5 flush ready", 64'(ready_o), 64'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 2 * STEPS; i++) begin
            tick();
            if (valid_o) sawValid = 1'b1;
        end
        checkOutput("T5 flush no valid", 64'(sawValid), 64'd0);
        checkOutput("T5 flush result kept", 64'(result_o), 64'h0000000F);

        applyStimulus(32'hCAFEF00D, 32'h0BADBEEF, 2'b00);
        for (int i = 0; i < 4; i++) tick();
        rst_n_i = 1'b0;
        #1;
        checkOutput("T5 reset ready low", 64'(ready_o), 64'd0);
        tick();
        checkOutput("T5 reset valid", 64'(valid_o), 64'd0);
        checkOutput("T5 reset result", 64'(result_o), 64'd0);
        rst_n_i = 1'b1;
        #1;
        checkOutput("T5 release ready", 64'(ready_o), 64'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 2 * STEPS; i++) begin
            tick();
            if (valid_o) sawValid = 1'b1;
        end
        checkOutput("T5 reset no valid", 64'(sawValid), 64'd0);

        // Random operations with output stalls and occasional back-to-back accepts.
        preAccepted = 1'b0;
        curA        = '0;
        curB        = '0;
        curMode     = 2'b00;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (!preAccepted) begin
                curA    = $urandom;
                curB    = $urandom;
                curMode = 2'($urandom_range(0, 3));
                applyStimulus(curA, curB, curMode);
            end
            expected = clmulModel(curA, curB, curMode);
            waitResult(cyc);
            checkOutput("T6 latency", 64'(cyc), 64'(STEPS));
            checkOutput("T6 result", 64'(result_o), 64'(expected));
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                tick();
                checkOutput("T6 stall result", 64'(result_o), 64'(expected));
            end
            if ($urandom_range(0, 1) == 1) begin
                curA        = $urandom;
                curB        = $urandom;
                curMode     = 2'($urandom_range(0, 3));
                operand_A_i = curA;
                operand_B_i = curB;
                mode_i      = curMode;
                valid_i     = 1'b1;
                ready_i     = 1'b1;
                #1;
                checkOutput("T6 b2b ready", 64'(ready_o), 64'd1);
                tick();
                valid_i     = 1'b0;
                ready_i     = 1'b0;
                preAccepted = 1'b1;
            end else begin
                consume();
                checkOutput("T6 valid drop", 64'(valid_o), 64'd0);
                preAccepted = 1'b0;
            end
        end
        if (preAccepted) begin
            expected = clmulModel(curA, curB, curMode);
            waitResult(cyc);
            checkOutput("T6 last result", 64'(result_o), 64'(expected));
            consume();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
